audio_adc_rx: RTL and testbench

Receives the WM8731 ADC serial stream (I2S, 16-bit, left channel) in the CLK50 domain and deserialises it into parallel samples for the recorder's SRAM writer. It presents each sample through a one-deep valid/ready buffer, together with an 18-bit sample index that serves directly as the SRAM word address. Recording stops when the SRAM is full. It is the capture-side counterpart of the playback path that drives DACDAT.

---
 rtl/audio_pkg.sv | 17 +
 rtl/audio_adc_rx_sync_edge.sv | 31 +++
 rtl/audio_adc_rx.sv | 137 +++++++++++++
 tb/tb_audio_adc_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared parameters and FSM state encoding for the WM8731
// ADC capture path.
//   SAMPLE_W_DEF : default bits per sample (16)
//   ADDR_W_DEF   : default sample-index / SRAM address width (18)
//   state_e      : capture FSM states
package audio_pkg;
  localparam int SAMPLE_W_DEF = 16;
  localparam int ADDR_W_DEF   = 18;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LRC,
    SKIP,
    SHIFT,
    PUSH
  } state_e;
endpackage

// File: rtl/audio_adc_rx_sync_edge.sv
// sync_edge: 3-flop synchroniser for an asynchronous codec clock with a
// registered single-cycle edge pulse.
//   clk_i  : system clock
//   rst_i  : async active-high reset
//   d_i    : asynchronous input
//   edge_o : one-cycle pulse on a rising (RISE=1) or falling (RISE=0) edge
module sync_edge #(
  parameter bit RISE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic edge_o
);
  logic [2:0] sync_q;
  logic       edge_q;

  // sync_q[1] is the first metastability-safe stage; sync_q[2] is the
  // one-cycle-old copy used as the edge reference.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
      edge_q <= RISE ? (sync_q[1] & ~sync_q[2]) : (~sync_q[1] & sync_q[2]);
    end
  end

  assign edge_o = edge_q;
endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: deserialises the left channel of the WM8731 I2S ADC stream
// into parallel samples, presented through a one-deep valid/ready buffer
// with an ADDR_W-bit sample index used directly as the SRAM word address.
//   CLK50, RST            : system clock, async active-high reset
//   BCLK, ADCLRCK, ADCDAT : codec serial interface (asynchronous)
//   enable                : record enable level; a rising edge starts a new take
//   sample_ready          : consumer accepts the buffered sample
//   sample_data/addr      : buffered sample and its index
//   sample_valid          : buffer holds an unconsumed sample
//   overrun               : sticky, a completed sample was dropped
//   full                  : 2^ADDR_W samples accepted, capture halted
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                CLK50,
  input  logic                RST,
  input  logic                BCLK,
  input  logic                ADCLRCK,
  input  logic                ADCDAT,
  input  logic                enable,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [ADDR_W-1:0]   sample_addr,
  output logic                sample_valid,
  output logic                overrun,
  output logic                full
);
  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam logic [ADDR_W:0]  CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  logic bclk_rise, lrc_fall;

  sync_edge #(.RISE(1'b1)) u_bclk (
    .clk_i(CLK50), .rst_i(RST), .d_i(BCLK), .edge_o(bclk_rise)
  );
  sync_edge #(.RISE(1'b0)) u_lrc (
    .clk_i(CLK50), .rst_i(RST), .d_i(ADCLRCK), .edge_o(lrc_fall)
  );

  state_e              state_q;
  logic [1:0]          dat_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic [CNT_W-1:0]    bit_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_d;
  logic                en_q;
  logic                en_rise;
  logic [SAMPLE_W-1:0] data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q, ovr_q, full_q;

  assign count_d = count_q + 1'b1;
  // en_q resets low, so enable already high at reset release arms a take.
  assign en_rise = enable & ~en_q;

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dat_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      en_q  <= enable;
      dat_q <= {dat_q[0], ADCDAT};

      // Consume first; a PUSH below in the same cycle re-sets valid.
      if (valid_q && sample_ready) valid_q <= 1'b0;

      if (state_q != IDLE && !enable) begin
        state_q <= IDLE;  // partial sample abandoned, buffer untouched
      end else begin
        case (state_q)
          IDLE: begin
            if (enable && (en_rise || !full_q)) begin
              state_q <= WAIT_LRC;
              if (en_rise) begin
                ovr_q   <= 1'b0;
                full_q  <= 1'b0;
                count_q <= '0;
              end
            end
          end
          WAIT_LRC: if (lrc_fall) state_q <= SKIP;
          // First BCLK rise after the left-channel start is the I2S delay slot.
          SKIP: if (!lrc_fall && bclk_rise) begin
            state_q <= SHIFT;
            bit_q   <= '0;
          end
          SHIFT: begin
            if (lrc_fall) begin
              state_q <= SKIP;  // short frame: restart on the new frame
            end else if (bclk_rise) begin
              shift_q <= {shift_q[SAMPLE_W-2:0], dat_q[1]};
              bit_q   <= bit_q + 1'b1;
              if (bit_q == LAST_BIT) state_q <= PUSH;
            end
          end
          PUSH: begin
            if (!valid_q || sample_ready) begin
              data_q  <= shift_q;
              addr_q  <= count_q[ADDR_W-1:0];
              valid_q <= 1'b1;
              count_q <= count_d;
              if (count_d == CNT_FULL) begin
                full_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= WAIT_LRC;
              end
            end else begin
              ovr_q   <= 1'b1;
              state_q <= WAIT_LRC;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sample_data  = data_q;
  assign sample_addr  = addr_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign full         = full_q;
endmodule

// File: tb/tb_audio_adc_rx.sv
module tb_audio_adc_rx;
  logic CLK50 = 1'b0;
  logic RST, BCLK, ADCLRCK, ADCDAT;
  logic en, rdy, en_s, rdy_s;

  logic [15:0] sample_data;
  logic [17:0] sample_addr;
  logic        sample_valid, overrun, full;
  logic [15:0] sd_s;
  logic [2:0]  sa_s;
  logic        sv_s, ov_s, fu_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } cap_t;
  cap_t q[$];
  cap_t qs[$];

  always #10 CLK50 = ~CLK50;

  audio_adc_rx #(.ADDR_W(18), .SAMPLE_W(16)) dut (
    .CLK50(CLK50), .RST(RST), .BCLK(BCLK), .ADCLRCK(ADCLRCK), .ADCDAT(ADCDAT),
    .enable(en), .sample_ready(rdy), .sample_data(sample_data),
    .sample_addr(sample_addr), .sample_valid(sample_valid),
    .overrun(overrun), .full(full)
  );

  audio_adc_rx #(.ADDR_W(3), .SAMPLE_W(16)) dut_s (
    .CLK50(CLK50), .RST(RST), .BCLK(BCLK), .ADCLRCK(ADCLRCK), .ADCDAT(ADCDAT),
    .enable(en_s), .sample_ready(rdy_s), .sample_data(sd_s),
    .sample_addr(sa_s), .sample_valid(sv_s),
    .overrun(ov_s), .full(fu_s)
  );

  // Record every handshake (valid & ready seen just before the next posedge).
  initial forever begin
    @(negedge CLK50);
    #1;
    if (sample_valid && rdy) q.push_back('{a: sample_addr, d: sample_data});
    if (sv_s && rdy_s) qs.push_back('{a: 18'(sa_s), d: sd_s});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic qchk(input string tag, input int idx, input logic [15:0] d, input logic [17:0] a);
    if (idx < q.size()) begin
      chk({tag, "_data"}, 32'(q[idx].d), 32'(d));
      chk({tag, "_addr"}, 32'(q[idx].a), 32'(a));
    end else begin
      chk({tag, "_missing"}, q.size(), idx + 1);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK50);
  endtask

  // One BCLK period: data/LRCK change on the falling edge, 8 CLK50 per half.
  task automatic slot(input logic lrc, input logic d);
    BCLK = 1'b0; ADCLRCK = lrc; ADCDAT = d;
    #160;
    BCLK = 1'b1;
    #160;
  endtask

  // Full I2S frame: 32 left slots then 32 right slots (right = FFFF).
  // drop/raise toggle enable, rst_on/rst_off pulse reset at the given left slot.
  task automatic frame(input logic [15:0] l, input int drop, input int raise,
                       input int rst_on, input int rst_off);
    logic [15:0] r;
    logic b;
    r = 16'hFFFF;
    @(negedge CLK50);
    for (int i = 0; i < 32; i++) begin
      if (i == drop)    en  = 1'b0;
      if (i == raise)   en  = 1'b1;
      if (i == rst_off) RST = 1'b0;
      if (i == rst_on) begin
        chk("rst_pre_valid", sample_valid, 1);
        RST = 1'b1;
        #1;
        chk("rst_valid", sample_valid, 0);
        chk("rst_data",  sample_data, 0);
        chk("rst_addr",  sample_addr, 0);
        chk("rst_ovr",   overrun, 0);
        chk("rst_full",  full, 0);
      end
      b = 1'b0;
      if (i >= 1 && i <= 16) b = l[16-i];
      slot(1'b0, b);
    end
    for (int i = 0; i < 32; i++) begin
      b = 1'b0;
      if (i >= 1 && i <= 16) b = r[16-i];
      slot(1'b1, b);
    end
  endtask

  task automatic plain(input logic [15:0] l);
    frame(l, -1, -1, -1, -1);
  endtask

  // Left channel cut after 9 data bits, then one right slot.
  task automatic short_frame(input logic [15:0] l);
    logic b;
    @(negedge CLK50);
    for (int i = 0; i < 10; i++) begin
      b = 1'b0;
      if (i >= 1) b = l[16-i];
      slot(1'b0, b);
    end
    slot(1'b1, 1'b0);
  endtask

  task automatic new_take();
    @(negedge CLK50);
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(3);
  endtask

  initial begin
    RST = 1'b1; BCLK = 1'b0; ADCLRCK = 1'b1; ADCDAT = 1'b0;
    en = 1'b0; rdy = 1'b0; en_s = 1'b0; rdy_s = 1'b1;
    cyc(5);
    chk("reset_valid", sample_valid, 0);
    chk("reset_data",  sample_data, 0);
    chk("reset_addr",  sample_addr, 0);
    chk("reset_ovr",   overrun, 0);
    chk("reset_full",  full, 0);
    RST = 1'b0;
    cyc(3);

    // Basic capture, consumer always ready.
    rdy = 1'b1;
    en  = 1'b1;
    cyc(3);
    for (int k = 0; k < 3; k++) plain(16'hA5C3);
    cyc(4);
    chk("basic_count", q.size(), 3);
    for (int k = 0; k < 3; k++) qchk("basic", k, 16'hA5C3, 18'(k));
    chk("basic_ovr", overrun, 0);
    chk("basic_valid_low", sample_valid, 0);

    // Backpressure: second sample dropped, overrun sticks.
    new_take();
    q.delete();
    rdy = 1'b0;
    plain(16'h1234);
    plain(16'h5678);
    cyc(2);
    chk("bp_valid", sample_valid, 1);
    chk("bp_data",  sample_data, 16'h1234);
    chk("bp_addr",  sample_addr, 0);
    chk("bp_ovr",   overrun, 1);
    rdy = 1'b1;
    cyc(3);
    plain(16'h9ABC);
    cyc(4);
    chk("bp_count", q.size(), 2);
    qchk("bp0", 0, 16'h1234, 0);
    qchk("bp1", 1, 16'h9ABC, 1);
    chk("bp_ovr_sticky", overrun, 1);

    // Enable dropped at bit 7 and raised mid-left-frame.
    q.delete();
    rdy = 1'b0;
    plain(16'h1111);
    frame(16'h3333, 7, 12, -1, -1);
    cyc(2);
    chk("en_buf_valid", sample_valid, 1);
    chk("en_buf_data",  sample_data, 16'h1111);
    chk("en_buf_addr",  sample_addr, 2);
    chk("en_ovr_clr",   overrun, 0);
    rdy = 1'b1;
    cyc(3);
    plain(16'h4444);
    cyc(4);
    chk("en_count", q.size(), 2);
    qchk("en0", 0, 16'h1111, 2);
    qchk("en1", 1, 16'h4444, 0);

    // Short frame followed by a good one.
    new_take();
    q.delete();
    short_frame(16'hFFFF);
    plain(16'h8001);
    cyc(4);
    chk("short_count", q.size(), 1);
    qchk("short", 0, 16'h8001, 0);

    // Full on the 3-bit-address instance.
    qs.delete();
    @(negedge CLK50);
    en_s = 1'b1;
    cyc(3);
    for (int k = 0; k < 9; k++) plain(16'h0100 + 16'(k));
    cyc(4);
    chk("full_count", qs.size(), 8);
    if (qs.size() >= 8) begin
      chk("full_first_addr", 32'(qs[0].a), 0);
      chk("full_last_data",  32'(qs[7].d), 32'h0107);
      chk("full_last_addr",  32'(qs[7].a), 7);
    end
    chk("full_flag", fu_s, 1);
    en_s = 1'b0;
    cyc(3);
    en_s = 1'b1;
    cyc(3);
    chk("full_clr", fu_s, 0);
    plain(16'h0BEE);
    cyc(4);
    chk("full_rearm_count", qs.size(), 9);
    if (qs.size() >= 9) begin
      chk("full_rearm_data", 32'(qs[8].d), 32'h0BEE);
      chk("full_rearm_addr", 32'(qs[8].a), 0);
    end
    en_s = 1'b0;

    // Async reset mid-SHIFT with a buffered sample; enable stays high.
    q.delete();
    rdy = 1'b0;
    plain(16'hAAAA);
    frame(16'h1357, -1, -1, 8, 10);
    @(negedge CLK50);
    chk("rst_after_valid", sample_valid, 0);
    rdy = 1'b1;
    cyc(3);
    plain(16'h5A5A);
    cyc(4);
    chk("rst_resume_count", q.size(), 1);
    qchk("rst_resume", 0, 16'h5A5A, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
